// File: rtl/rsa_pkg.sv
// rsa_pkg: shared state type, default operand width and counter-width helper for the RSA exponentiator.
package rsa_pkg;
  typedef enum logic [2:0] {IDLE, PREP, MONT, UPD, DONE} state_e;
  localparam int DEF_WIDTH = 256;
  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction
endpackage

// File: rtl/rsa_mont_step.sv
// rsa_mont_step: one radix-2 Montgomery iteration, v_o = (v_i + b_i*y_i + q*n_i) / 2 with q the sum's LSB.
module rsa_mont_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH+1:0] v_i,
  input  logic             b_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic [WIDTH-1:0] n_i,
  output logic [WIDTH+1:0] v_o
);
  logic [WIDTH+2:0] sum, tot;
  assign sum = {1'b0, v_i} + (b_i ? {3'b0, y_i} : '0);
  assign tot = sum + (sum[0] ? {3'b0, n_i} : '0);
  assign v_o = tot[WIDTH+2:1];
endmodule

// File: rtl/rsa_mont_exp.sv
// rsa_mont_exp: a^e mod n via right-to-left binary exponentiation over radix-2 Montgomery products.
// Optional RSA_ABORT_EN adds i_abort, which drops any operation in flight back to IDLE without a result.
module rsa_mont_exp
  import rsa_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_e,
  input  logic [CNT_W-1:0] i_e_len,
  input  logic [WIDTH-1:0] i_n,
`ifdef RSA_ABORT_EN
  input  logic             i_abort,
`endif
  output logic             o_ready,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_a_pow_e,
  output logic             o_finished
);
  localparam int IW = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] WMAX = CNT_W'(WIDTH);
  state_e state_q, state_d;
  logic [WIDTH-1:0] e_q, n_q, s_q, t_q, res_q;
  logic [WIDTH+1:0] vs_q, vt_q, vs_nx, vt_nx;
  logic [CNT_W-1:0] len_q, cnt_q, k_q;
  logic [WIDTH:0] t2;
  logic fin_q, abort, cnt_end, e_bit;
`ifdef RSA_ABORT_EN
  assign abort = i_abort;
`else
  assign abort = 1'b0;
`endif
  assign cnt_end = cnt_q == LAST;
  assign e_bit = e_q[k_q[IW-1:0]];
  assign t2 = {t_q, 1'b0};
  rsa_mont_step #(.WIDTH(WIDTH)) u_vt (
    .v_i(vt_q), .b_i(t_q[cnt_q[IW-1:0]]), .y_i(t_q), .n_i(n_q), .v_o(vt_nx)
  );
  rsa_mont_step #(.WIDTH(WIDTH)) u_vs (
    .v_i(vs_q), .b_i(s_q[cnt_q[IW-1:0]]), .y_i(t_q), .n_i(n_q), .v_o(vs_nx)
  );
  always_ff @(posedge i_clk) state_q <= i_rst ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = i_start ? PREP : IDLE;
      PREP: state_d = !cnt_end ? PREP : (len_q == '0 ? DONE : MONT);
      MONT: state_d = cnt_end ? UPD : MONT;
      UPD: state_d = k_q == len_q - 1'b1 ? DONE : MONT;
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) state_d = IDLE;
  end
  always_comb begin
    o_ready = state_q == IDLE;
    o_busy = state_q != IDLE;
    o_a_pow_e = res_q;
    o_finished = fin_q;
  end
  // T lives in the Montgomery domain (a*2^WIDTH), S in the normal domain, so S is the final answer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      e_q <= '0;
      n_q <= '0;
      s_q <= '0;
      t_q <= '0;
      vs_q <= '0;
      vt_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      k_q <= '0;
      res_q <= '0;
      fin_q <= 1'b0;
    end else begin
      fin_q <= state_q == DONE && !abort;
      case (state_q)
        IDLE: if (i_start) begin
          e_q <= i_e;
          n_q <= i_n;
          len_q <= i_e_len > WMAX ? WMAX : i_e_len;
          s_q <= WIDTH'(1);
          t_q <= i_a;
          cnt_q <= '0;
        end
        PREP: begin
          t_q <= WIDTH'(t2 >= {1'b0, n_q} ? t2 - {1'b0, n_q} : t2);
          cnt_q <= cnt_end ? '0 : cnt_q + 1'b1;
          k_q <= '0;
          vs_q <= '0;
          vt_q <= '0;
        end
        MONT: begin
          vt_q <= vt_nx;
          if (e_bit) vs_q <= vs_nx;
          cnt_q <= cnt_end ? '0 : cnt_q + 1'b1;
        end
        UPD: begin
          t_q <= WIDTH'(vt_q >= {2'b0, n_q} ? vt_q - {2'b0, n_q} : vt_q);
          if (e_bit) s_q <= WIDTH'(vs_q >= {2'b0, n_q} ? vs_q - {2'b0, n_q} : vs_q);
          k_q <= k_q + 1'b1;
          vs_q <= '0;
          vt_q <= '0;
        end
        DONE: if (!abort) res_q <= s_q;
        default: ;
      endcase
    end
  end
endmodule
